// File: rtl/div36x15_seq.sv
// Sequential radix-2 restoring unsigned divider, 36-bit dividend by 15-bit divisor, one bit per clock.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration loop and finishes on the next edge.
module div36x15_seq #(
  parameter int unsigned DW = 36,
  parameter int unsigned RW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [RW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quot,
  output logic [RW-1:0] rem,
  output logic          div_zero
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] sh_q, sh_d;
  // The partial remainder never reaches the divisor, so only its low RW bits are stored.
  // The trial value t carries the extra bit.
  logic [RW-1:0] p_q, p_d;
  logic [RW-1:0] d_q, d_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [RW:0]   t;
  logic [RW:0]   diff;
  logic          ge;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    p_d     = p_q;
    d_d     = d_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    t    = {p_q, sh_q[DW-1]};
    ge   = (t >= {1'b0, d_q});
    diff = t - {1'b0, d_q};

    case (state_q)
      StIdle: begin
        if (start) begin
          sh_d    = dividend;
          d_d     = divisor;
          p_d     = '0;
          count_d = CW'(DW - 1);
          state_d = StRun;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend[RW-1:0];
            dz_d    = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        p_d  = ge ? diff[RW-1:0] : t[RW-1:0];
        sh_d = {sh_q[DW-2:0], ge};
        if (count_q == '0) begin
          // Results are published only on the transition into StDone.
          quot_d  = sh_d;
          rem_d   = p_d;
          dz_d    = (d_q == '0);
          state_d = StDone;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      p_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      p_q     <= p_d;
      d_q     <= d_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign done     = (state_q == StDone);
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div36x15_seq.sv
// Scoreboard bench for div36x15_seq: stimulus pushes expected results, a monitor checks each done pulse.
module tb_div36x15_seq;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLat = 1;
`else
  localparam int ZLat = 37;
`endif
  localparam int NLat = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [35:0] dividend = '0;
  logic [14:0] divisor = '0;
  logic        ready, done, div_zero;
  logic [35:0] quot;
  logic [14:0] rem;

  div36x15_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [35:0] q;
    logic [14:0] r;
    logic        z;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int dones = 0;
  int accepts = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("quot", 64'(quot), 64'(e.q));
        chk("rem", 64'(rem), 64'(e.r));
        chk("div_zero", 64'(div_zero), 64'(e.z));
        chk("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called at a negedge; leaves at a later negedge with start low.
  task automatic issue(input logic [35:0] a, input logic [14:0] b,
                       input logic [35:0] q, input logic [14:0] r);
    int n;
    int lat;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 64'(ready), 64'd1);
      return;
    end
    lat = (b == '0) ? ZLat : NLat;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back('{q, r, (b == '0), cyc + lat});
    accepts++;
    @(negedge clk);
    start    = 1'b0;
    // Operands only matter on the accepting edge.
    dividend = 36'h5_A5A5_A5A5;
    divisor  = 15'h1234;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  // Directed vectors: dividend, divisor, quotient, remainder.
  localparam int NV = 8;
  logic [35:0] va [NV] = '{36'hF_FFFF_FFFF, 36'd0, 36'd100, 36'd65536,
                           36'd1000000, 36'd14, 36'd32767, 36'd123456789};
  logic [14:0] vb [NV] = '{15'd1, 15'd5, 15'd100, 15'd3,
                           15'd1000, 15'h7FFF, 15'h7FFF, 15'd12345};
  logic [35:0] vq [NV] = '{36'hF_FFFF_FFFF, 36'd0, 36'd1, 36'd21845,
                           36'd1000, 36'd0, 36'd1, 36'd10000};
  logic [14:0] vr [NV] = '{15'd0, 15'd0, 15'd0, 15'd1,
                           15'd0, 15'd14, 15'd0, 15'd6789};

  initial begin
    #2;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quot", 64'(quot), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T1 plus hold check in IDLE
    issue(36'd1000, 15'd7, 36'd142, 15'd6);
    drain();
    repeat (5) @(negedge clk);
    chk("hold_quot", 64'(quot), 64'd142);
    chk("hold_rem", 64'(rem), 64'd6);
    chk("hold_ready", 64'(ready), 64'd1);

    // T2
    issue(36'hF_FFFF_FFFF, 15'h7FFF, 36'h0_0020_0040, 15'd63);
    drain();

    // T3: start held through RUN, operands changed while busy
    start    = 1'b1;
    dividend = 36'd5;
    divisor  = 15'd9;
    sb.push_back('{36'd0, 15'd5, 1'b0, cyc + NLat});
    accepts++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dividend = 36'd999;
      divisor  = 15'd1;
      if (i == 10) chk("busy_ready", 64'(ready), 64'd0);
    end
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("t3_quot_stable", 64'(quot), 64'd0);
    chk("t3_rem_stable", 64'(rem), 64'd5);

    // T4: zero divisor
    issue(36'h123, 15'd0, 36'hF_FFFF_FFFF, 15'h123);
    drain();

    for (int i = 0; i < NV; i++) begin
      issue(va[i], vb[i], vq[i], vr[i]);
      drain();
    end

    // T5: asynchronous reset mid-run aborts without a done pulse
    start    = 1'b1;
    dividend = 36'd1000;
    divisor  = 15'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_quot", 64'(quot), 64'd0);
    chk("abort_rem", 64'(rem), 64'd0);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    issue(36'd49, 15'd7, 36'd7, 15'd0);
    drain();

    chk("done_count", 64'(dones), 64'(accepts));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
